md_rotate_unit: RTL and testbench
=================================

# md_rotate_unit

Execution unit for PowerISA 3.0B MD/MDS-format rotate instructions: rldicl, rldicr, rldic, rldimi, rldcl, rldcr. It sits downstream of the MD-format decoder and consumes that decoder's field outputs plus a function select. It reads the needed GPRs one at a time over a single register-file read port. It computes the rotate and mask result, then writes RA, and CR0 when Rc=1, through a handshaked writeback port.

## Interface
Parameters:
- `addressSize`, 64: GPR / datapath width.
- `opcodeWidth`, 6: primary opcode width.
- `regWidth`, 5: GPR index width.

Ports (clock and reset first):
- `clock_i` in 1: single clock.
- `resetn_i` in 1: reset, synchronous, active-low.
- `enable_i` in 1: decoded op valid.
- `opcode_i` in 6: must equal 30, else the op is ignored.
- `func_i` in 3: 0 rldicl, 1 rldicr, 2 rldic, 3 rldimi, 4 rldcl, 5 rldcr; 6–7 ignored.
- `reg1_i` in 5: RS index.
- `reg2_i` in 5: RA index (destination; also the source for rldimi).
- `reg3_i` in 5: RB index (MDS only).
- `imm_i` in 64: MD carries instr[16:26] in imm[53:63]; MDS carries instr[21:26] in imm[58:63].
- `bit1_i` in 1: MD sh5; MDS Rc.
- `bit2_i` in 1: MD Rc; MDS ignored.
- `xerSo_i` in 1: XER.SO, copied into CR0[3].
- `ready_o` out 1: high only in IDLE.
- `rdReq_o` out 1, `rdAddr_o` out 5: register-file read request.
- `rdAck_i` in 1, `rdData_i` in 64: read handshake.
- `wbValid_o` out 1, `wbAddr_o` out 5, `wbData_o` out 64: RA writeback.
- `crValid_o` out 1, `cr0_o` out 4: CR0 update {LT,GT,EQ,SO}.
- `wbAck_i` in 1: writeback accepted.

## Operation
- Bit numbering is big-endian: bit 0 is the MSB.
- Field extraction:
  - MD: sh = {bit1_i, imm_i[53:57]}; mask field mf = {imm_i[63], imm_i[58:62]}; Rc = bit2_i.
  - MDS: mf is the same; Rc = bit1_i; sh = RB[58:63].
- Mask MASK(x,y):
  - x ≤ y: ones in bits x..y.
  - x > y: ones in bits 0..y and x..63 (wrap-around).
- Results, with r = ROTL64(RS, sh):
  - rldicl, rldcl: r & MASK(mf,63).
  - rldicr, rldcr: r & MASK(0,mf).
  - rldic: r & MASK(mf,63−sh).
  - rldimi: (r & m) | (RA & ~m), with m = MASK(mf,63−sh).
- FSM states: IDLE, RD_RS, RD_RB, RD_RA, EXEC, WB.
  - IDLE → RD_RS on enable_i & opcode_i==30 & func_i≤5. All fields are latched at this edge.
  - RD_RS → RD_RB (func 4,5), → RD_RA (func 3), else → EXEC. Each RD_* state advances only on the edge where rdAck_i=1, capturing rdData_i.
  - EXEC → WB unconditionally. wbData, wbAddr and cr0 are registered here.
  - WB → IDLE on the edge where wbAck_i=1. All WB outputs hold stable while wbAck_i=0.
- rdReq_o=1 and rdAddr_o = index of the current RD_* register, exactly while in an RD_* state.
- CR0, only when Rc=1: LT = result[0]; GT = !result[0] & result≠0; EQ = result==0; SO = xerSo_i sampled in EXEC. crValid_o = Rc during WB; otherwise 0.
- enable_i while ready_o=0 is ignored; upstream must hold the op. An invalid opcode or func leaves the unit in IDLE.
- Reset values: state IDLE, ready_o=1, all other outputs 0.
- Reset asserted in any state returns the unit to IDLE on that edge; any pending read or writeback is abandoned.

## Timing
- With rdAck_i and wbAck_i tied high: accept at edge 0, RD_RS at cycle 1, EXEC at 2, WB visible at cycle 3, ready_o high again at cycle 4.
- Each extra source read (rldcl/rldcr, rldimi) adds +1 cycle. Each stall cycle on either ack adds +1 cycle.
- The unit accepts one op per transaction; there is no overlap between ops.

## Structure
- Shared package `rotate_pkg` holds:
  - func_i encodings;
  - FSM state enum;
  - opcode constant 30;
  - CR0 bit positions.
- Sub-module `md_mask_gen`: combinational, inputs x[6], y[6], output mask[64], with wrap handling. It is instantiated once in EXEC. The rotate itself stays inline.

## Test plan
- rldicl, RS=0x8000000000000001, sh=1, mf=0, Rc=0 → wbData=0x0000000000000003, crValid=0, WB at cycle 3.
- rldicr, RS=0xFFFFFFFFFFFFFFFF, sh=0, mf=31, Rc=1, xerSo=0 → wbData=0xFFFFFFFF00000000, cr0=1000.
- rldimi, RS=0xAB, RA=0xFFFFFFFFFFFFFFFF, sh=8, mf=48 → reads issued RS then RA; wbData=0xFFFFFFFFFFFFABFF.
- rldcl, RS=1, RB=0x45, mf=0, with rdAck delayed 2 cycles per read → rdAddr sequence is reg1 then reg3; wbData=0x20; WB at cycle 8.
- rldic (wrap-around mask), RS=all ones, sh=4, mf=62, Rc=1, xerSo=1 → wbData=0xFFFFFFFFFFFFFFF3, cr0=1001. Hold wbAck low 3 cycles → outputs stable for those cycles, then ready_o returns high.
- resetn_i low while in RD_RB with rdReq_o=1 → on the next cycle rdReq_o=0, wbValid_o=0, ready_o=1. A new op is then accepted normally.

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared definitions for the MD/MDS-format rotate unit: function codes,
// FSM states, the primary opcode and CR0 field positions.
package rotate_pkg;

    typedef enum logic [2:0] {
        FN_RLDICL = 3'd0,
        FN_RLDICR = 3'd1,
        FN_RLDIC  = 3'd2,
        FN_RLDIMI = 3'd3,
        FN_RLDCL  = 3'd4,
        FN_RLDCR  = 3'd5
    } func_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_RS = 3'd1,
        ST_RD_RB = 3'd2,
        ST_RD_RA = 3'd3,
        ST_EXEC  = 3'd4,
        ST_WB    = 3'd5
    } state_t;

    localparam int OPCODE_MD_ROT = 30;
    localparam int FUNC_MAX      = 5;

    // CR0 is presented as {LT,GT,EQ,SO}, LT in the most significant bit
    localparam int CR0_LT = 3;
    localparam int CR0_GT = 2;
    localparam int CR0_EQ = 1;
    localparam int CR0_SO = 0;

    // MDS forms take the shift amount from RB instead of the immediate
    function automatic logic is_mds(input func_t fn);
        return (fn == FN_RLDCL) || (fn == FN_RLDCR);
    endfunction

endpackage

// File: rtl/md_mask_gen.sv
// Combinational PowerISA MASK(x,y) generator; x and y use big-endian bit
// numbering (bit 0 is the MSB) and x > y produces a wrap-around mask.
module md_mask_gen (
    input  logic [5:0]  x,
    input  logic [5:0]  y,
    output logic [63:0] mask
);

    logic no_wrap;
    assign no_wrap = (x <= y);

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_bit
            localparam logic [5:0] POS = 6'(gi);
            // Big-endian position gi lives at little-endian index 63-gi
            assign mask[63-gi] = no_wrap ? ((POS >= x) && (POS <= y))
                                         : ((POS <= y) || (POS >= x));
        end
    endgenerate

endmodule

// File: rtl/md_rotate_unit.sv
// Execution unit for rldicl/rldicr/rldic/rldimi/rldcl/rldcr: fetches sources
// over one register-file read port, rotates and masks, then writes back RA/CR0.
module md_rotate_unit
    import rotate_pkg::*;
#(
    parameter int addressSize = 64,
    parameter int opcodeWidth = 6,
    parameter int regWidth    = 5
) (
    input  logic                   clock_i,
    input  logic                   resetn_i,
    input  logic                   enable_i,
    input  logic [opcodeWidth-1:0] opcode_i,
    input  logic [2:0]             func_i,
    input  logic [regWidth-1:0]    reg1_i,
    input  logic [regWidth-1:0]    reg2_i,
    input  logic [regWidth-1:0]    reg3_i,
    input  logic [addressSize-1:0] imm_i,
    input  logic                   bit1_i,
    input  logic                   bit2_i,
    input  logic                   xerSo_i,
    output logic                   ready_o,
    output logic                   rdReq_o,
    output logic [regWidth-1:0]    rdAddr_o,
    input  logic                   rdAck_i,
    input  logic [addressSize-1:0] rdData_i,
    output logic                   wbValid_o,
    output logic [regWidth-1:0]    wbAddr_o,
    output logic [addressSize-1:0] wbData_o,
    output logic                   crValid_o,
    output logic [3:0]             cr0_o,
    input  logic                   wbAck_i
);

    state_t                 state_reg, state_next;
    func_t                  func_reg;
    logic [regWidth-1:0]    rs_idx_reg, ra_idx_reg, rb_idx_reg;
    logic [5:0]             sh_reg, mf_reg;
    logic                   rc_reg;
    logic [addressSize-1:0] rs_reg, ra_reg;
    logic [addressSize-1:0] wb_data_reg;
    logic [regWidth-1:0]    wb_addr_reg;
    logic [3:0]             cr0_reg;

    logic                   accept;
    logic                   rd_req;
    logic [regWidth-1:0]    rd_addr;
    logic [5:0]             mask_x, mask_y;
    logic [63:0]            mask;
    logic [2*addressSize-1:0] rot_wide;
    logic [addressSize-1:0] rot, result;
    logic [3:0]             cr0_next;
    logic [5:0]             md_sh, md_mf;
    logic                   unused_imm;

    assign accept = enable_i && (opcode_i == opcodeWidth'(OPCODE_MD_ROT))
                    && (func_i <= 3'(FUNC_MAX));

    // imm[53:57] (big-endian) is sh[0:4]; mf is imm[63] || imm[58:62]
    assign md_sh      = {bit1_i, imm_i[10:6]};
    assign md_mf      = {imm_i[0], imm_i[5:1]};
    assign unused_imm = ^imm_i[addressSize-1:11];

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rd_req     = 1'b0;
        rd_addr    = '0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_RD_RS;
            end
            ST_RD_RS: begin
                rd_req  = 1'b1;
                rd_addr = rs_idx_reg;
                if (rdAck_i) begin
                    if (is_mds(func_reg))          state_next = ST_RD_RB;
                    else if (func_reg == FN_RLDIMI) state_next = ST_RD_RA;
                    else                            state_next = ST_EXEC;
                end
            end
            ST_RD_RB: begin
                rd_req  = 1'b1;
                rd_addr = rb_idx_reg;
                if (rdAck_i) state_next = ST_EXEC;
            end
            ST_RD_RA: begin
                rd_req  = 1'b1;
                rd_addr = ra_idx_reg;
                if (rdAck_i) state_next = ST_EXEC;
            end
            ST_EXEC: state_next = ST_WB;
            ST_WB: begin
                if (wbAck_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Rotate left: the upper half of the doubled operand shifted left by sh
    assign rot_wide = {rs_reg, rs_reg} << sh_reg;
    assign rot      = rot_wide[2*addressSize-1:addressSize];

    always_comb begin
        mask_x = mf_reg;
        mask_y = 6'd63;
        case (func_reg)
            FN_RLDICR, FN_RLDCR: begin
                mask_x = 6'd0;
                mask_y = mf_reg;
            end
            FN_RLDIC, FN_RLDIMI: mask_y = ~sh_reg;  // 63 - sh
            default: ;
        endcase
    end

    md_mask_gen u_mask_gen (
        .x    (mask_x),
        .y    (mask_y),
        .mask (mask)
    );

    always_comb begin
        if (func_reg == FN_RLDIMI) result = (rot & mask) | (ra_reg & ~mask);
        else                       result = rot & mask;
        cr0_next         = 4'b0000;
        if (rc_reg) begin
            cr0_next[CR0_LT] = result[addressSize-1];
            cr0_next[CR0_GT] = !result[addressSize-1] && (|result);
            cr0_next[CR0_EQ] = ~|result;
            cr0_next[CR0_SO] = xerSo_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            func_reg    <= FN_RLDICL;
            rs_idx_reg  <= '0;
            ra_idx_reg  <= '0;
            rb_idx_reg  <= '0;
            sh_reg      <= '0;
            mf_reg      <= '0;
            rc_reg      <= 1'b0;
            rs_reg      <= '0;
            ra_reg      <= '0;
            wb_data_reg <= '0;
            wb_addr_reg <= '0;
            cr0_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        func_reg   <= func_t'(func_i);
                        rs_idx_reg <= reg1_i;
                        ra_idx_reg <= reg2_i;
                        rb_idx_reg <= reg3_i;
                        sh_reg     <= md_sh;
                        mf_reg     <= md_mf;
                        rc_reg     <= is_mds(func_t'(func_i)) ? bit1_i : bit2_i;
                    end
                end
                ST_RD_RS: if (rdAck_i) rs_reg <= rdData_i;
                ST_RD_RB: if (rdAck_i) sh_reg <= rdData_i[5:0];
                ST_RD_RA: if (rdAck_i) ra_reg <= rdData_i;
                ST_EXEC: begin
                    wb_data_reg <= result;
                    wb_addr_reg <= ra_idx_reg;
                    cr0_reg     <= cr0_next;
                end
                default: ;
            endcase
        end
    end

    assign ready_o   = (state_reg == ST_IDLE);
    assign rdReq_o   = rd_req;
    assign rdAddr_o  = rd_addr;
    assign wbValid_o = (state_reg == ST_WB);
    assign wbAddr_o  = wb_addr_reg;
    assign wbData_o  = wb_data_reg;
    assign crValid_o = (state_reg == ST_WB) && rc_reg;
    assign cr0_o     = cr0_reg;

endmodule

// File: tb/tb_md_rotate_unit.sv
// Self-checking bench for md_rotate_unit: directed cases from the rotate
// semantics, randomized ops against a big-endian behavioural model, resets.
module tb_md_rotate_unit;

    logic        clock_i = 1'b0;
    logic        resetn_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [5:0]  opcode_i = '0;
    logic [2:0]  func_i = '0;
    logic [4:0]  reg1_i = '0, reg2_i = '0, reg3_i = '0;
    logic [63:0] imm_i = '0;
    logic        bit1_i = 1'b0, bit2_i = 1'b0, xerSo_i = 1'b0;
    logic        ready_o, rdReq_o, rdAck_i = 1'b0;
    logic [4:0]  rdAddr_o;
    logic [63:0] rdData_i = '0;
    logic        wbValid_o, crValid_o, wbAck_i = 1'b0;
    logic [4:0]  wbAddr_o;
    logic [63:0] wbData_o;
    logic [3:0]  cr0_o;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] regs [32];

    always #5 clock_i = ~clock_i;

    md_rotate_unit dut (
        .clock_i(clock_i), .resetn_i(resetn_i), .enable_i(enable_i),
        .opcode_i(opcode_i), .func_i(func_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
        .reg3_i(reg3_i), .imm_i(imm_i), .bit1_i(bit1_i), .bit2_i(bit2_i),
        .xerSo_i(xerSo_i), .ready_o(ready_o), .rdReq_o(rdReq_o),
        .rdAddr_o(rdAddr_o), .rdAck_i(rdAck_i), .rdData_i(rdData_i),
        .wbValid_o(wbValid_o), .wbAddr_o(wbAddr_o), .wbData_o(wbData_o),
        .crValid_o(crValid_o), .cr0_o(cr0_o), .wbAck_i(wbAck_i)
    );

    // ---------------- behavioural model (big-endian bit view) ----------------
    function automatic logic ibit(input logic [63:0] v, input int k);
        return v[63-k];
    endfunction

    function automatic logic [63:0] ref_mask(input int x, input int y);
        logic [63:0] m = '0;
        for (int k = 0; k < 64; k++)
            if ((x <= y && k >= x && k <= y) || (x > y && (k <= y || k >= x)))
                m[63-k] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] ref_rotl(input logic [63:0] v, input int n);
        logic [63:0] r = '0;
        for (int k = 0; k < 64; k++) r[63-k] = ibit(v, (k + n) % 64);
        return r;
    endfunction

    function automatic logic [63:0] ref_exec(input int fn, input logic [63:0] rs,
            input logic [63:0] ra, input logic [63:0] rb, input logic [63:0] imm,
            input logic b1);
        int sh, mf;
        logic [63:0] r, m;
        mf = ibit(imm, 63) ? 32 : 0;
        for (int k = 58; k <= 62; k++) mf += ibit(imm, k) << (62 - k);
        if (fn >= 4) sh = int'(rb % 64);
        else begin
            sh = b1 ? 32 : 0;
            for (int k = 53; k <= 57; k++) sh += ibit(imm, k) << (57 - k);
        end
        r = ref_rotl(rs, sh);
        case (fn)
            0, 4:    m = ref_mask(mf, 63);
            1, 5:    m = ref_mask(0, mf);
            default: m = ref_mask(mf, 63 - sh);
        endcase
        return (fn == 3) ? ((r & m) | (ra & ~m)) : (r & m);
    endfunction

    function automatic logic [3:0] ref_cr0(input logic [63:0] res, input logic so);
        logic neg = ibit(res, 0);
        return {neg, !neg && res != 0, res == 0, so};
    endfunction

    // Place sh and mf in the MD immediate layout; other bits come from junk
    function automatic logic [63:0] mk_imm(input int sh, input int mf, input logic [63:0] junk);
        logic [63:0] v = junk;
        for (int i = 0; i < 5; i++) v[63-(53+i)] = 1'((sh >> (4 - i)) & 1);
        for (int i = 0; i < 5; i++) v[63-(58+i)] = 1'((mf >> (4 - i)) & 1);
        v[0] = 1'((mf >> 5) & 1);
        return v;
    endfunction

    // ---------------- transaction driver ----------------
    task automatic run_op(input int fn, input logic [4:0] r1, input logic [4:0] r2,
            input logic [4:0] r3, input logic [63:0] imm, input logic b1, input logic b2,
            input logic so, input int rd_dly, input int wb_dly, input bit scramble,
            output logic [63:0] data, output logic [4:0] addr, output logic [3:0] cr,
            output logic crv, output int wb_cyc, output int rdy_cyc, output int nreads,
            output logic [14:0] rd_seq, output bit unstable, output bit early_rdy,
            output bit timeout);
        int cyc = 0, rstall = 0, wstall = 0;
        bit seen_wb = 0, done = 0;
        data = '0; addr = '0; cr = '0; crv = 1'b0; wb_cyc = -1; rdy_cyc = -1;
        nreads = 0; rd_seq = '0; unstable = 0; early_rdy = 0; timeout = 0;
        @(negedge clock_i);
        enable_i = 1'b1; opcode_i = 6'd30; func_i = 3'(fn);
        reg1_i = r1; reg2_i = r2; reg3_i = r3; imm_i = imm;
        bit1_i = b1; bit2_i = b2; xerSo_i = so;
        @(posedge clock_i);
        while (!done && cyc < 200) begin
            @(negedge clock_i);
            cyc++;
            if (scramble) begin
                enable_i = 1'b1; func_i = 3'($urandom_range(0, 5));
                reg1_i = 5'($urandom); reg2_i = 5'($urandom); reg3_i = 5'($urandom);
                imm_i = {$urandom, $urandom}; bit1_i = 1'($urandom); bit2_i = 1'($urandom);
            end else enable_i = 1'b0;
            rdAck_i = 1'b0; wbAck_i = 1'b0;
            if (ready_o && seen_wb) begin
                rdy_cyc = cyc; done = 1; enable_i = 1'b0;
            end else begin
                if (ready_o) early_rdy = 1;
                if (rdReq_o) begin
                    if (rstall == rd_dly) begin
                        rdAck_i = 1'b1; rdData_i = regs[rdAddr_o];
                        if (nreads < 3) rd_seq[nreads*5 +: 5] = rdAddr_o;
                        nreads++; rstall = 0;
                    end else rstall++;
                end
                if (wbValid_o) begin
                    if (!seen_wb) begin
                        seen_wb = 1; wb_cyc = cyc; data = wbData_o; addr = wbAddr_o;
                        cr = cr0_o; crv = crValid_o;
                    end else if (wbData_o !== data || wbAddr_o !== addr ||
                                 cr0_o !== cr || crValid_o !== crv) unstable = 1;
                    if (wstall == wb_dly) begin wbAck_i = 1'b1; wstall = 0; end
                    else wstall++;
                end
                @(posedge clock_i);
            end
        end
        if (!done) timeout = 1;
        enable_i = 1'b0; rdAck_i = 1'b0; wbAck_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn_i = 1'b0;
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        if ({ready_o, rdReq_o, rdAddr_o, wbValid_o, wbAddr_o, crValid_o, cr0_o} !== 18'h20000) begin
            $display("FAIL reset_ctrl: got ready=%b rdReq=%b rdAddr=%0d wbValid=%b wbAddr=%0d crValid=%b cr0=%b want ready=1 others 0",
                     ready_o, rdReq_o, rdAddr_o, wbValid_o, wbAddr_o, crValid_o, cr0_o);
            miscompares++;
        end
        vectors++;
        if (wbData_o !== 64'h0) begin
            $display("FAIL reset_wbdata: got %h want 0", wbData_o); miscompares++;
        end
        vectors++;
        resetn_i = 1'b1;
        $display("reset: ready=%b rdReq=%b wbValid=%b", ready_o, rdReq_o, wbValid_o);
    endtask

    task automatic test_directed();
        logic [63:0] d; logic [4:0] a; logic [3:0] c; logic cv;
        int wc, rc, nr; logic [14:0] seq; bit un, er, to;
        // rldicl: rotate by 1, full mask
        regs[1] = 64'h8000000000000001;
        run_op(0, 5'd1, 5'd2, 5'd0, mk_imm(1, 0, 64'h0), 0, 0, 0, 0, 0, 0,
               d, a, c, cv, wc, rc, nr, seq, un, er, to);
        $display("rldicl: data=%h crValid=%b wb@%0d ready@%0d", d, cv, wc, rc);
        if (d !== 64'h3 || cv !== 1'b0 || a !== 5'd2) begin
            $display("FAIL rldicl_result: got %h/cv%b/ra%0d want 0000000000000003/cv0/ra2", d, cv, a); miscompares++;
        end
        vectors++;
        if (wc != 3 || rc != 4 || er || to) begin
            $display("FAIL rldicl_timing: got wb@%0d ready@%0d early=%0d to=%0d want wb@3 ready@4", wc, rc, er, to); miscompares++;
        end
        vectors++;
        // rldicr: upper-word mask, CR0 negative
        regs[3] = '1;
        run_op(1, 5'd3, 5'd9, 5'd0, mk_imm(0, 31, 64'h0), 0, 1, 0, 0, 0, 0,
               d, a, c, cv, wc, rc, nr, seq, un, er, to);
        $display("rldicr: data=%h cr0=%b crValid=%b", d, c, cv);
        if (d !== 64'hFFFFFFFF00000000 || c !== 4'b1000 || cv !== 1'b1) begin
            $display("FAIL rldicr_result: got %h cr0=%b cv=%b want FFFFFFFF00000000 cr0=1000 cv=1", d, c, cv); miscompares++;
        end
        vectors++;
        // rldimi: insert, reads RS then RA
        regs[4] = 64'hAB; regs[5] = '1;
        run_op(3, 5'd4, 5'd5, 5'd0, mk_imm(8, 48, 64'h0), 0, 0, 0, 0, 0, 0,
               d, a, c, cv, wc, rc, nr, seq, un, er, to);
        $display("rldimi: data=%h reads=%0d seq=%0d,%0d wb@%0d", d, nr, seq[4:0], seq[9:5], wc);
        if (d !== 64'hFFFFFFFFFFFFABFF || a !== 5'd5) begin
            $display("FAIL rldimi_result: got %h ra%0d want FFFFFFFFFFFFABFF ra5", d, a); miscompares++;
        end
        vectors++;
        if (nr != 2 || seq[9:0] !== {5'd5, 5'd4} || wc != 4) begin
            $display("FAIL rldimi_reads: got n=%0d seq=%0d,%0d wb@%0d want n=2 seq=4,5 wb@4", nr, seq[4:0], seq[9:5], wc); miscompares++;
        end
        vectors++;
        // rldcl: shift from RB, two-cycle read stalls
        regs[6] = 64'h1; regs[7] = 64'h45;
        run_op(4, 5'd6, 5'd10, 5'd7, mk_imm(0, 0, 64'h0), 0, 0, 0, 2, 0, 0,
               d, a, c, cv, wc, rc, nr, seq, un, er, to);
        $display("rldcl: data=%h seq=%0d,%0d wb@%0d", d, seq[4:0], seq[9:5], wc);
        if (d !== 64'h20) begin
            $display("FAIL rldcl_result: got %h want 0000000000000020", d); miscompares++;
        end
        vectors++;
        if (nr != 2 || seq[9:0] !== {5'd7, 5'd6} || wc != 8) begin
            $display("FAIL rldcl_timing: got n=%0d seq=%0d,%0d wb@%0d want n=2 seq=6,7 wb@8", nr, seq[4:0], seq[9:5], wc); miscompares++;
        end
        vectors++;
        // rldic: wrap-around mask, SO set, writeback stalled 3 cycles
        regs[8] = '1;
        run_op(2, 5'd8, 5'd11, 5'd0, mk_imm(4, 62, 64'h0), 0, 1, 1, 0, 3, 0,
               d, a, c, cv, wc, rc, nr, seq, un, er, to);
        $display("rldic: data=%h cr0=%b wb@%0d ready@%0d", d, c, wc, rc);
        if (d !== 64'hFFFFFFFFFFFFFFF3 || c !== 4'b1001) begin
            $display("FAIL rldic_result: got %h cr0=%b want FFFFFFFFFFFFFFF3 cr0=1001", d, c); miscompares++;
        end
        vectors++;
        if (un || wc != 3 || rc != 7 || to) begin
            $display("FAIL rldic_stall: got unstable=%0d wb@%0d ready@%0d want stable wb@3 ready@7", un, wc, rc); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_random(input int n, input bit scramble);
        logic [63:0] d, exp_d, imm; logic [4:0] a, r1, r2, r3; logic [3:0] c;
        logic cv, b1, b2, so, exp_rc;
        int wc, rc, nr, fn, rdd, wbd, exp_n, exp_wc; logic [14:0] seq, exp_seq;
        bit un, er, to;
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
            fn = $urandom_range(0, 5);
            r1 = 5'($urandom); r2 = 5'($urandom); r3 = 5'($urandom);
            imm = {$urandom, $urandom}; b1 = 1'($urandom); b2 = 1'($urandom); so = 1'($urandom);
            rdd = scramble ? 0 : $urandom_range(0, 2);
            wbd = scramble ? 0 : $urandom_range(0, 2);
            run_op(fn, r1, r2, r3, imm, b1, b2, so, rdd, wbd, scramble,
                   d, a, c, cv, wc, rc, nr, seq, un, er, to);
            exp_d  = ref_exec(fn, regs[r1], regs[r2], regs[r3], imm, b1);
            exp_rc = (fn >= 4) ? b1 : b2;
            exp_n  = (fn >= 3) ? 2 : 1;
            exp_seq = {5'd0, (fn >= 4) ? r3 : r2, r1};
            if (exp_n == 1) exp_seq[9:5] = 5'd0;
            exp_wc = 2 + exp_n * (rdd + 1);
            $display("op%0d fn=%0d rs=%0d ra=%0d rb=%0d data=%h cr0=%b crv=%b wb@%0d ready@%0d",
                     t, fn, r1, r2, r3, d, c, cv, wc, rc);
            if (d !== exp_d || a !== r2) begin
                $display("FAIL rand_data op%0d: got %h ra%0d want %h ra%0d", t, d, a, exp_d, r2); miscompares++;
            end
            vectors++;
            if (cv !== exp_rc || (exp_rc && c !== ref_cr0(exp_d, so))) begin
                $display("FAIL rand_cr0 op%0d: got cv=%b cr0=%b want cv=%b cr0=%b", t, cv, c, exp_rc, ref_cr0(exp_d, so)); miscompares++;
            end
            vectors++;
            if (nr != exp_n || seq !== exp_seq) begin
                $display("FAIL rand_reads op%0d: got n=%0d seq=%h want n=%0d seq=%h", t, nr, seq, exp_n, exp_seq); miscompares++;
            end
            vectors++;
            if (wc != exp_wc || rc != exp_wc + wbd + 1 || un || er || to) begin
                $display("FAIL rand_timing op%0d: got wb@%0d ready@%0d un=%0d early=%0d to=%0d want wb@%0d ready@%0d",
                         t, wc, rc, un, er, to, exp_wc, exp_wc + wbd + 1); miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_invalid();
        bit bad;
        logic [8:0] pats [3];
        pats[0] = {6'd31, 3'd0}; pats[1] = {6'd30, 3'd6}; pats[2] = {6'd30, 3'd7};
        for (int p = 0; p < 3; p++) begin
            bad = 0;
            @(negedge clock_i);
            enable_i = 1'b1; opcode_i = pats[p][8:3]; func_i = pats[p][2:0];
            for (int c = 0; c < 3; c++) begin
                @(negedge clock_i);
                if (!ready_o || rdReq_o || wbValid_o) bad = 1;
            end
            enable_i = 1'b0;
            $display("invalid op=%0d func=%0d: ready=%b rdReq=%b", pats[p][8:3], pats[p][2:0], ready_o, rdReq_o);
            if (bad) begin
                $display("FAIL invalid_ignored op=%0d func=%0d: got ready=%b rdReq=%b want ready=1 rdReq=0",
                         pats[p][8:3], pats[p][2:0], ready_o, rdReq_o);
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_reset_midop();
        bit found = 0;
        logic [63:0] d; logic [4:0] a; logic [3:0] c; logic cv;
        int wc, rc, nr; logic [14:0] seq; bit un, er, to;
        regs[6] = 64'h1; regs[7] = 64'h45;
        @(negedge clock_i);
        enable_i = 1'b1; opcode_i = 6'd30; func_i = 3'd4;
        reg1_i = 5'd6; reg2_i = 5'd12; reg3_i = 5'd7; imm_i = '0; bit1_i = 1'b0;
        @(posedge clock_i);
        for (int c2 = 0; c2 < 10 && !found; c2++) begin
            @(negedge clock_i);
            enable_i = 1'b0; rdAck_i = 1'b0;
            if (rdReq_o && rdAddr_o == 5'd7) found = 1;
            else begin
                if (rdReq_o) begin rdAck_i = 1'b1; rdData_i = regs[rdAddr_o]; end
                @(posedge clock_i);
            end
        end
        rdAck_i = 1'b0;
        resetn_i = 1'b0;
        @(posedge clock_i);
        @(negedge clock_i);
        resetn_i = 1'b1;
        $display("reset in RD_RB: found=%0d rdReq=%b wbValid=%b ready=%b", found, rdReq_o, wbValid_o, ready_o);
        if (!found || rdReq_o !== 1'b0 || wbValid_o !== 1'b0 || ready_o !== 1'b1) begin
            $display("FAIL reset_midop: got found=%0d rdReq=%b wbValid=%b ready=%b want found=1 rdReq=0 wbValid=0 ready=1",
                     found, rdReq_o, wbValid_o, ready_o);
            miscompares++;
        end
        vectors++;
        run_op(4, 5'd6, 5'd12, 5'd7, mk_imm(0, 0, 64'h0), 0, 0, 0, 0, 0, 0,
               d, a, c, cv, wc, rc, nr, seq, un, er, to);
        $display("after reset rldcl: data=%h wb@%0d", d, wc);
        if (d !== 64'h20 || a !== 5'd12 || wc != 4 || to) begin
            $display("FAIL post_reset_op: got %h ra%0d wb@%0d want 0000000000000020 ra12 wb@4", d, a, wc); miscompares++;
        end
        vectors++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        test_reset();
        test_directed();
        test_random(40, 0);
        test_random(10, 1);
        test_invalid();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
